// File: rtl/core_pkg.sv
// Shared definitions for the instruction-fetch slice: widths, reset PC and the
// entry handed to decode.
package core_pkg;

    localparam int CORE_XLEN = 32;
    localparam logic [CORE_XLEN-1:0] CORE_PC_START = 32'h0000_0200;

    // One decoded-side queue entry; fields are CORE_XLEN wide, so cores built
    // with a narrower XLEN zero-extend into it.
    typedef struct packed {
        logic [CORE_XLEN-1:0] pc;
        logic [CORE_XLEN-1:0] pc4;
        logic [CORE_XLEN-1:0] instr;
    } fetch_entry_t;

    // Occupancy counters need one extra bit to represent "completely full".
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/core_fetch_fifo.sv
// Small synchronous FIFO with flush and a first-word-fall-through head; used
// both for the decode queue and for the PCs of requests still in flight.
module core_fetch_fifo
    import core_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head_data,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          do_push, do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign count   = count_reg;
    assign do_push = push && !flush && !full;
    assign do_pop  = pop && !flush && !empty;

    // Head is read straight from registered storage, so a push is visible
    // on the following cycle without any combinational input-to-output path.
    assign head_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_next = wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Callers size their traffic by credits; a push into a full FIFO is a bug.
    assert property (@(posedge clk) disable iff (!n_rst) !(push && full && !flush));

endmodule

// File: rtl/core_fetch_q.sv
// Fetch PC generator plus in-order L1I request tracking and decode queue,
// with redirect that flushes the queue and kills stale responses.
module core_fetch_q
    import core_pkg::*;
#(
    parameter int              XLEN     = CORE_XLEN,
    parameter logic [XLEN-1:0] PC_START = XLEN'(CORE_PC_START),
    parameter int              QDEPTH   = 4
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            redir_val,
    input  logic [XLEN-1:0] redir_addr,
    output logic            ic_req_val,
    output logic [XLEN-1:0] ic_req_addr,
    input  logic            ic_req_rdy,
    input  logic            ic_resp_val,
    input  logic [XLEN-1:0] ic_resp_data,
    output logic            dec_val,
    input  logic            dec_rdy,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_pc4,
    output logic [XLEN-1:0] dec_instr
);

    localparam int CW = cnt_width(QDEPTH);
    localparam int EW = $bits(fetch_entry_t);

    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [CW-1:0]   kill_cnt_reg, kill_cnt_next;
    logic            started_reg;

    logic [XLEN-1:0] pcq_head;
    logic            pcq_empty, pcq_full;
    logic [CW-1:0]   pcq_count;

    logic [EW-1:0]   iq_push_data, iq_head;
    logic            iq_empty, iq_full;
    logic [CW-1:0]   iq_count;
    logic            iq_push, iq_pop;

    fetch_entry_t    push_entry, head_entry;
    logic [CW:0]     credit_sum;
    logic            room, req_fire, resp_hit, killing;

    // Killed requests still hold a credit until their response comes back.
    assign credit_sum  = {1'b0, pcq_count} + {1'b0, iq_count};
    assign room        = !pcq_full && !iq_full && (credit_sum < (CW+1)'(QDEPTH));
    assign ic_req_val  = n_rst && started_reg && !redir_val && room;
    assign ic_req_addr = fetch_pc_reg;
    assign req_fire    = ic_req_val && ic_req_rdy;

    assign resp_hit = ic_resp_val && !pcq_empty;
    assign killing  = (kill_cnt_reg != '0);
    assign iq_push  = resp_hit && !killing && !redir_val;
    assign iq_pop   = dec_val && dec_rdy && !redir_val;

    always_comb begin
        push_entry       = '0;
        push_entry.pc    = CORE_XLEN'(pcq_head);
        push_entry.pc4   = CORE_XLEN'(pcq_head + XLEN'(4));
        push_entry.instr = CORE_XLEN'(ic_resp_data);
    end
    assign iq_push_data = push_entry;
    assign head_entry   = fetch_entry_t'(iq_head);

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        kill_cnt_next = kill_cnt_reg;
        if (redir_val) begin
            fetch_pc_next = {redir_addr[XLEN-1:2], 2'b00};
            // Everything in flight except a response landing this cycle is stale.
            kill_cnt_next = pcq_count - CW'(resp_hit);
        end else begin
            if (req_fire) begin
                fetch_pc_next = fetch_pc_reg + XLEN'(4);
            end
            if (resp_hit && killing) begin
                kill_cnt_next = kill_cnt_reg - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            fetch_pc_reg <= PC_START;
            kill_cnt_reg <= '0;
            started_reg  <= 1'b0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            kill_cnt_reg <= kill_cnt_next;
            started_reg  <= 1'b1;
        end
    end

    // PCs of issued requests, popped in order as the L1I answers.
    core_fetch_fifo #(
        .W     (XLEN),
        .DEPTH (QDEPTH)
    ) u_pc_q (
        .clk       (clk),
        .n_rst     (n_rst),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (fetch_pc_reg),
        .pop       (ic_resp_val),
        .head_data (pcq_head),
        .empty     (pcq_empty),
        .full      (pcq_full),
        .count     (pcq_count)
    );

    core_fetch_fifo #(
        .W     (EW),
        .DEPTH (QDEPTH)
    ) u_instr_q (
        .clk       (clk),
        .n_rst     (n_rst),
        .flush     (redir_val),
        .push      (iq_push),
        .push_data (iq_push_data),
        .pop       (iq_pop),
        .head_data (iq_head),
        .empty     (iq_empty),
        .full      (iq_full),
        .count     (iq_count)
    );

    assign dec_val   = n_rst && !iq_empty;
    assign dec_pc    = dec_val ? XLEN'(head_entry.pc)    : '0;
    assign dec_pc4   = dec_val ? XLEN'(head_entry.pc4)   : '0;
    assign dec_instr = dec_val ? XLEN'(head_entry.instr) : '0;

endmodule

// File: tb/tb_core_fetch_q.sv
// Self-checking bench: an in-order L1I model with random latency drives the
// fetch queue; an epoch-based reference model predicts requests and decode.
module tb_core_fetch_q;

    localparam int          QD  = 4;
    localparam logic [31:0] PCS = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        redir_val = 1'b0;
    logic [31:0] redir_addr = '0;
    logic        ic_req_val;
    logic [31:0] ic_req_addr;
    logic        ic_req_rdy = 1'b0;
    logic        ic_resp_val = 1'b0;
    logic [31:0] ic_resp_data = '0;
    logic        dec_val;
    logic        dec_rdy = 1'b0;
    logic [31:0] dec_pc, dec_pc4, dec_instr;

    core_fetch_q #(
        .XLEN     (32),
        .PC_START (PCS),
        .QDEPTH   (QD)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .redir_val    (redir_val),
        .redir_addr   (redir_addr),
        .ic_req_val   (ic_req_val),
        .ic_req_addr  (ic_req_addr),
        .ic_req_rdy   (ic_req_rdy),
        .ic_resp_val  (ic_resp_val),
        .ic_resp_data (ic_resp_data),
        .dec_val      (dec_val),
        .dec_rdy      (dec_rdy),
        .dec_pc       (dec_pc),
        .dec_pc4      (dec_pc4),
        .dec_instr    (dec_instr)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] pc; int epoch; int due;} req_t;
    typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;

    req_t        pend[$];
    ent_t        mq[$];
    logic [31:0] acc_log[$];
    logic [31:0] dec_log[$];
    int          checks = 0, errors = 0;
    int          epoch = 0, cyc = 0, since_rst = 0, last_due = 0, lat_max = 1;
    int          n_acc_dut = 0;
    logic [31:0] exp_req_pc = PCS;
    logic [31:0] held_pc;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] acc_at(input int i);
        return (acc_log.size() > i) ? acc_log[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] dec_at(input int i);
        return (dec_log.size() > i) ? dec_log[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, update model at posedge.
    task automatic step(input logic rd, input logic [31:0] ra, input logic rq_rdy, input logic d_rdy);
        logic resp, exp_val, ev_acc, ev_pop, have_head;
        req_t r;
        int   due;
        redir_val  = rd;
        redir_addr = ra;
        ic_req_rdy = rq_rdy;
        dec_rdy    = d_rdy;
        resp = n_rst && (pend.size() > 0) && (pend[0].due <= cyc);
        ic_resp_val  = resp;
        ic_resp_data = resp ? instr_of(pend[0].pc) : $urandom();
        @(negedge clk);
        exp_val = n_rst && (since_rst >= 1) && !rd && (pend.size() + mq.size() < QD);
        chk("ic_req_val", 32'(ic_req_val), 32'(exp_val));
        if (exp_val) chk("ic_req_addr", ic_req_addr, exp_req_pc);
        have_head = n_rst && (mq.size() > 0);
        chk("dec_val", 32'(dec_val), 32'(have_head));
        if (have_head) begin
            chk("dec_pc", dec_pc, mq[0].pc);
            chk("dec_pc4", dec_pc4, mq[0].pc + 32'd4);
            chk("dec_instr", dec_instr, mq[0].instr);
        end else begin
            chk("dec_pc_idle", dec_pc, 32'h0);
            chk("dec_pc4_idle", dec_pc4, 32'h0);
            chk("dec_instr_idle", dec_instr, 32'h0);
        end
        if (ic_req_val && ic_req_rdy) begin
            n_acc_dut++;
            acc_log.push_back(ic_req_addr);
        end
        if (dec_val && dec_rdy && !rd) dec_log.push_back(dec_pc);
        ev_acc = exp_val && rq_rdy;
        ev_pop = have_head && d_rdy && !rd;
        @(posedge clk);
        #1;
        cyc++;
        if (!n_rst) begin
            pend.delete();
            mq.delete();
            exp_req_pc = PCS;
            since_rst  = 0;
            last_due   = 0;
            return;
        end
        since_rst++;
        if (resp) r = pend.pop_front();
        if (rd) begin
            epoch++;
            mq.delete();
            exp_req_pc = {ra[31:2], 2'b00};
        end else begin
            if (ev_pop) void'(mq.pop_front());
            if (resp && r.epoch == epoch) mq.push_back('{pc: r.pc, instr: instr_of(r.pc)});
            if (ev_acc) begin
                due = cyc + int'($urandom_range(lat_max - 1, 0));
                if (due < last_due) due = last_due;
                last_due = due;
                pend.push_back('{pc: exp_req_pc, epoch: epoch, due: due});
                exp_req_pc = exp_req_pc + 32'd4;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        repeat (2) step(1'b0, '0, 1'b1, 1'b0);
        n_rst = 1'b1;

        // Straight-line fetch after reset, single-cycle L1I.
        lat_max = 1;
        acc_log.delete();
        dec_log.delete();
        repeat (12) step(1'b0, '0, 1'b1, 1'b1);
        chk("first_req0", acc_at(0), 32'h0000_0200);
        chk("first_req1", acc_at(1), 32'h0000_0204);
        chk("first_req2", acc_at(2), 32'h0000_0208);
        chk("first_dec", dec_at(0), 32'h0000_0200);

        // Credit limit: stalled decode allows exactly QD requests, one per pop.
        repeat (4) step(1'b0, '0, 1'b0, 1'b1);
        n_acc_dut = 0;
        repeat (10) step(1'b0, '0, 1'b1, 1'b0);
        chk("credit_fill", 32'(n_acc_dut), 32'(QD));
        n_acc_dut = 0;
        step(1'b0, '0, 1'b1, 1'b1);
        repeat (5) step(1'b0, '0, 1'b1, 1'b0);
        chk("credit_one", 32'(n_acc_dut), 32'd1);

        // L1I back-pressure holds the request address.
        repeat (6) step(1'b0, '0, 1'b0, 1'b1);
        held_pc = exp_req_pc;
        repeat (5) step(1'b0, '0, 1'b0, 1'b1);
        acc_log.delete();
        step(1'b0, '0, 1'b1, 1'b1);
        chk("stall_release", acc_at(0), held_pc);

        // Redirect with several requests outstanding; target low bits dropped.
        lat_max = 8;
        for (int i = 0; i < 30 && pend.size() < 3; i++) step(1'b0, '0, 1'b1, 1'b1);
        acc_log.delete();
        dec_log.delete();
        step(1'b1, 32'h0000_1003, 1'b1, 1'b1);
        lat_max = 1;
        repeat (20) step(1'b0, '0, 1'b1, 1'b1);
        chk("redir_req", acc_at(0), 32'h0000_1000);
        chk("redir_dec", dec_at(0), 32'h0000_1000);

        // PC wraps from the top of the address space to zero.
        step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        acc_log.delete();
        repeat (6) step(1'b0, '0, 1'b1, 1'b1);
        chk("wrap_fffc", acc_at(1), 32'hFFFF_FFFC);
        chk("wrap_zero", acc_at(2), 32'h0000_0000);

        // Back-to-back redirects while stale responses are still in flight.
        lat_max = 3;
        for (int i = 0; i < 30 && !(mq.size() > 0 && pend.size() > 1); i++) step(1'b0, '0, 1'b1, 1'b1);
        step(1'b1, 32'h0000_4000, 1'b1, 1'b1);
        step(1'b1, 32'h0000_5002, 1'b1, 1'b1);
        dec_log.delete();
        repeat (25) step(1'b0, '0, 1'b1, 1'b1);
        chk("double_redir_dec", dec_at(0), 32'h0000_5000);

        // Reset in the middle of traffic.
        repeat (5) step(1'b0, '0, 1'b1, 1'b0);
        n_rst = 1'b0;
        repeat (2) step(1'b0, '0, 1'b1, 1'b1);
        n_rst = 1'b1;
        acc_log.delete();
        repeat (6) step(1'b0, '0, 1'b1, 1'b1);
        chk("rst_restart", acc_at(0), PCS);

        // Random traffic against the reference model.
        for (int i = 0; i < 900; i++) begin
            logic        rd;
            logic [31:0] ra;
            if (i % 100 == 0) lat_max = int'($urandom_range(4, 1));
            rd = ($urandom_range(99, 0) < 4);
            ra = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
            step(rd, ra, ($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_fetch_q.md
CORE_FETCH_Q -- requirements
Module: core_fetch_q

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/instruction width.
REQ-002 SHALL have parameter PC_START, default 32'h0000_0200, PC value after reset.
REQ-003 SHALL have parameter QDEPTH, default 4, fetch-queue entries; legal values are powers of two from 2 to 16.
REQ-004 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-005 SHALL have port n_rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port redir_val  in  1  redirect (branch/trap) request.
REQ-007 SHALL have port redir_addr  in  XLEN  redirect target; bits [1:0] ignored, treated as 0.
REQ-008 SHALL have port ic_req_val  out  1  L1I request valid.
REQ-009 SHALL have port ic_req_addr  out  XLEN  L1I request address, word aligned.
REQ-010 SHALL have port ic_req_rdy  in  1  L1I accepts request.
REQ-011 SHALL have port ic_resp_val  in  1  L1I response valid; responses return in request order, never back-pressured.
REQ-012 SHALL have port ic_resp_data  in  XLEN  instruction word.
REQ-013 SHALL have port dec_val  out  1  queue head valid to decode.
REQ-014 SHALL have port dec_rdy  in  1  decode consumes head.
REQ-015 SHALL have ports dec_pc, dec_pc4, dec_instr  out  XLEN each  head PC, PC+4, instruction.

Function
REQ-016 SHALL issue a request (ic_req_val=1) when redir_val=0 and outstanding+occupancy < QDEPTH; ic_req_addr = fetch PC.
REQ-017 SHALL advance fetch PC by 4 (modulo 2^XLEN, wrap from all-ones-minus-3 to 0) only on the cycle ic_req_val&&ic_req_rdy.
REQ-018 SHALL hold ic_req_addr stable while ic_req_val=1 and ic_req_rdy=0, unless redir_val asserts.
REQ-019 SHALL record issued PC in order alongside each outstanding request; on a non-killed ic_resp_val, push {pc, pc+4, data} into the queue.
REQ-020 SHALL present a pushed entry on dec_* one cycle after the response (no combinational resp-to-dec path).
REQ-021 SHALL pop head on dec_val&&dec_rdy; same-cycle push and pop leave occupancy unchanged.
REQ-022 SHALL never overflow: credit rule REQ-016 guarantees space; push into a full queue is an assertion failure.
REQ-023 SHALL, on redir_val=1: force ic_req_val=0 that cycle, load fetch PC with redir_addr&~3, empty the queue (dec_val=0 next cycle), and set kill count = outstanding requests not answered in that cycle.
REQ-024 SHALL drop responses while kill count > 0, decrementing per dropped response; dropped responses never reach the queue.
REQ-025 SHALL treat a redirect while kill count > 0 as replacing it with all current outstanding requests (old and new remain killed).
REQ-026 SHALL resume issuing at redir_addr the cycle after redirect, even with kills pending (credits count killed requests as outstanding).
REQ-027 SHALL let redir_val dominate simultaneous dec_rdy pop and resp push: queue empty afterwards.
REQ-028 SHALL keep dec_* stable while dec_val=1 and dec_rdy=0.

Reset
REQ-029 SHALL on n_rst=0 at a clock edge set fetch PC=PC_START, occupancy, outstanding and kill counts =0.
REQ-030 SHALL drive ic_req_val=0, dec_val=0, dec_pc=dec_pc4=dec_instr=0 while in reset and in the first cycle after.
REQ-031 SHALL discard in-flight responses arriving after reset mid-operation; the L1I is reset with the same n_rst.

Structure
REQ-032 SHALL take PC_START default, XLEN default and the queue-entry struct {pc, pc4, instr} from shared package core_pkg.
REQ-033 SHALL instantiate one sub-module core_fetch_fifo (parametrised sync FIFO with flush) for the instruction queue; the PC-tracking queue for outstanding requests uses the same sub-module.
REQ-034 SHALL be 120-400 lines of synthesizable RTL with no latches.

Verification
REQ-035 Reset, ic_req_rdy=1, 1-cycle L1I -> requests 0x200,0x204,0x208... on consecutive cycles; dec_pc=0x200, dec_instr matches, dec_pc4=0x204.
REQ-036 QDEPTH=4, dec_rdy=0 -> exactly 4 requests issued, then ic_req_val=0 until a pop; one pop -> one new request.
REQ-037 3 outstanding, redir_val with redir_addr=0x1003 -> next request 0x1000; 3 stale responses dropped; first dec_pc=0x1000.
REQ-038 ic_req_rdy=0 for 5 cycles -> ic_req_addr held constant, PC not advanced.
REQ-039 PC=0xFFFF_FFFC, request accepted -> next request address 0x0000_0000.
REQ-040 Redirect same cycle as pop and response, then second redirect before kills drain -> queue empty, only responses to post-redirect requests delivered.
